riscv_c_fetch_align: RTL

- Instruction realigner between the 32-bit fetch interface and decode, for cores with the C (compressed) extension.
- Splits each fetched 32-bit word into 16-bit and 32-bit instructions. 32-bit instructions that straddle two fetch words are reassembled in a one-halfword buffer.
- Presents one instruction per handshake with its PC and a compressed flag.
- Handles redirects to halfword-aligned targets.

---
 rtl/riscv_c_fetch_align.sv | 119 +++++++++++
 1 files changed

// File: rtl/riscv_c_fetch_align.sv
// Realigns 32-bit fetch words into a stream of 16/32-bit RISC-V instructions,
// reassembling 32-bit instructions that straddle fetch words in a halfword buffer.
module riscv_c_fetch_align #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            fch_vld,
  output logic            fch_rdy,
  input  logic [31:0]     fch_dat,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [31:0]     out_ins,
  output logic [XLEN-1:0] out_pc,
  output logic            out_cmp
);

  logic [15:0]     hbuf_q, hbuf_d;
  logic            bv_q, bv_d;
  logic            skip_q, skip_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [15:0] lo_half, hi_half;
  logic        hbuf_cmp, lo_cmp, hi_cmp;
  logic        out_hs;

  assign lo_half  = fch_dat[15:0];
  assign hi_half  = fch_dat[31:16];
  assign hbuf_cmp = (hbuf_q[1:0] != 2'b11);
  assign lo_cmp   = (lo_half[1:0] != 2'b11);
  assign hi_cmp   = (hi_half[1:0] != 2'b11);
  assign out_pc   = pc_q;
  assign out_hs   = out_vld & out_rdy;

  always_comb begin
    out_vld = 1'b0;
    fch_rdy = 1'b0;
    out_ins = fch_dat;
    out_cmp = 1'b0;
    hbuf_d  = hbuf_q;
    bv_d    = bv_q;
    skip_d  = skip_q;
    pc_d    = pc_q;

    if (rst) begin
      out_vld = 1'b0;
      fch_rdy = 1'b0;
    end else if (flush) begin
      bv_d   = 1'b0;
      pc_d   = flush_pc & ~{{(XLEN-1){1'b0}}, 1'b1};
      skip_d = flush_pc[1];
    end else if (bv_q && hbuf_cmp) begin
      // Buffered compressed halfword drains without touching the fetch side.
      out_vld = 1'b1;
      out_ins = {16'h0000, hbuf_q};
      out_cmp = 1'b1;
      if (out_rdy) bv_d = 1'b0;
    end else if (bv_q) begin
      out_vld = fch_vld;
      out_ins = {lo_half, hbuf_q};
      fch_rdy = out_rdy;
      if (fch_vld && out_rdy) begin
        hbuf_d = hi_half;
        bv_d   = 1'b1;
      end
    end else if (skip_q) begin
      if (hi_cmp) begin
        out_vld = fch_vld;
        out_ins = {16'h0000, hi_half};
        out_cmp = 1'b1;
        fch_rdy = out_rdy;
        if (fch_vld && out_rdy) skip_d = 1'b0;
      end else begin
        // Upper half starts a 32-bit instruction: swallow the word, emit nothing.
        fch_rdy = 1'b1;
        if (fch_vld) begin
          hbuf_d = hi_half;
          bv_d   = 1'b1;
          skip_d = 1'b0;
        end
      end
    end else if (lo_cmp) begin
      out_vld = fch_vld;
      out_ins = {16'h0000, lo_half};
      out_cmp = 1'b1;
      fch_rdy = out_rdy;
      if (fch_vld && out_rdy) begin
        hbuf_d = hi_half;
        bv_d   = 1'b1;
      end
    end else begin
      out_vld = fch_vld;
      out_ins = fch_dat;
      fch_rdy = out_rdy;
    end

    if (!rst && !flush && out_hs) begin
      pc_d = out_cmp ? pc_q + XLEN'(2) : pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hbuf_q <= 16'h0000;
      bv_q   <= 1'b0;
      skip_q <= 1'b0;
      pc_q   <= RESET_PC;
    end else begin
      hbuf_q <= hbuf_d;
      bv_q   <= bv_d;
      skip_q <= skip_d;
      pc_q   <= pc_d;
    end
  end

endmodule
